uart_tx_periph: RTL and testbench

Memory-mapped UART transmitter with an 8-entry byte FIFO. It sits on the CPU_RV32I data bus beside the data RAM, downstream of the address decoder. It consumes bus writes (busWe/busAddr/busWData) and returns register contents on its read-data output, which the decoder muxes into busRData. Frames are 8N1, LSB first, and the bit period is set by a software-programmable divisor.

---
 rtl/uart_tx_periph.sv | 135 +++++++++++++
 tb/tb_uart_tx_periph.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO and a programmable bit divisor.
// Registers: TXDATA (0x0), STATUS (0x4), BAUDDIV (0x8), CTRL (0xC).
module uart_tx_periph #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wData,
  output logic [31:0] rData,
  output logic        tx,
  output logic        irq
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_next;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          ovf, enable;
  logic [15:0]   baud_div, div_q, div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          full, empty, push, push_ok, pop, bit_end, busy, status_wr;
  logic          unused_bits;

  assign unused_bits = ^{wData[31:16], addr[1:0]};

  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push      = sel && we && (addr[3:2] == 2'd0);
  assign status_wr = sel && we && (addr[3:2] == 2'd1);
  assign push_ok   = push && !full;
  assign pop       = (state == IDLE) && enable && !empty;
  assign bit_end   = (div_cnt == div_q);

  always_comb begin
    count_next = count;
    if (push_ok && !pop)      count_next = count + CW'(1);
    else if (!push_ok && pop) count_next = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pop) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && bit_cnt == 3'd7) state_next = STOP;
      STOP:    if (bit_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx   = 1'b1;
    busy = 1'b1;
    case (state)
      IDLE:    busy = 1'b0;
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      STOP:    tx = 1'b1;
      default: ;
    endcase
  end

  // FIFO storage needs no reset; emptiness is carried by count alone.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem[wr_ptr] <= wData[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf      <= 1'b0;
      enable   <= 1'b1;
      baud_div <= DIV_RESET;
      div_q    <= DIV_RESET;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      irq      <= 1'b1;
    end else begin
      count <= count_next;
      irq   <= (count_next == '0) && (state_next == IDLE);
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push && full)             ovf <= 1'b1;
      else if (status_wr && wData[3]) ovf <= 1'b0;
      if (sel && we && addr[3:2] == 2'd2) baud_div <= wData[15:0];
      if (sel && we && addr[3:2] == 2'd3) enable   <= wData[0];
      // Divisor is captured at pop so BAUDDIV writes only affect the next frame.
      if (pop) begin
        shift   <= mem[rd_ptr];
        div_q   <= baud_div;
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (state != IDLE) begin
        if (bit_end) begin
          div_cnt <= '0;
          if (state == DATA) begin
            shift   <= {1'b0, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
        end else begin
          div_cnt <= div_cnt + 16'd1;
        end
      end
    end
  end

  always_comb begin
    rData = '0;
    if (sel) begin
      case (addr[3:2])
        2'd1:    rData[7:0]  = {4'(count), ovf, empty, full, busy};
        2'd2:    rData[15:0] = baud_div;
        2'd3:    rData[0]    = enable;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: register vector table, plus a serial-line decoder
// that checks every frame bit-by-bit against a scoreboard of expected bytes.
module tb_uart_tx_periph;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wData = '0;
  logic [31:0] rData;
  logic        tx;
  logic        irq;

  uart_tx_periph #(.FIFO_DEPTH(8), .DIV_RESET(16'd868)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr),
    .wData(wData), .rData(rData), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    int unsigned period;
  } exp_frame_t;

  typedef struct {
    logic        s;
    logic        w;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  exp_frame_t  sb[$];
  int unsigned start_q[$];
  vec_t        vecs[16];
  int          checks = 0;
  int          failures = 0;
  logic        abort_req = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive at negedge, sample read data, hold through the edge.
  task automatic access(input logic s, input logic w, input logic [3:0] a,
                        input logic [31:0] d, output logic [31:0] r);
    @(negedge clk);
    sel = s; we = w; addr = a; wData = d;
    #1 r = rData;
    @(posedge clk);
    #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic wait_irq(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (irq) break;
      @(posedge clk);
      #1;
    end
    check(name, 32'(irq), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Serial decoder: every negedge sample inside a frame must match the ideal waveform.
  initial begin : decoder
    logic        prev;
    exp_frame_t  e;
    logic [9:0]  pat;
    logic [7:0]  got;
    logic        bad;
    logic        aborted;
    int unsigned p;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (abort_req) begin
        abort_req = 1'b0;
        prev = tx;
      end else begin
        if (prev === 1'b1 && tx === 1'b0) begin
          start_q.push_back(cyc);
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame: start bit at cycle %0d, no byte expected", cyc);
          end else begin
            e = sb.pop_front();
            p = e.period;
            pat = {1'b1, e.data, 1'b0};
            bad = 1'b0;
            got = '0;
            aborted = 1'b0;
            for (int j = 0; j < 10 * int'(p); j++) begin
              if (j != 0) @(negedge clk);
              if (abort_req) begin
                aborted = 1'b1;
                break;
              end
              if (tx !== pat[j / int'(p)]) bad = 1'b1;
              if ((j % int'(p)) == int'(p) / 2 && j / int'(p) >= 1 && j / int'(p) <= 8)
                got[j / int'(p) - 1] = tx;
            end
            if (aborted) abort_req = 1'b0;
            else check("frame", 32'({bad, got}), 32'({1'b0, e.data}));
          end
        end
        prev = tx;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin : main
    logic [31:0] r;
    int unsigned t0;
    logic [7:0]  b;

    vecs[0]  = '{1'b1, 1'b0, 4'h4, 32'h0,          32'h4};
    vecs[1]  = '{1'b1, 1'b0, 4'h8, 32'h0,          32'h364};
    vecs[2]  = '{1'b1, 1'b0, 4'hC, 32'h0,          32'h1};
    vecs[3]  = '{1'b1, 1'b0, 4'h0, 32'h0,          32'h0};
    vecs[4]  = '{1'b0, 1'b0, 4'h4, 32'h0,          32'h0};
    vecs[5]  = '{1'b1, 1'b1, 4'h8, 32'hABCD_1234,  32'h0};
    vecs[6]  = '{1'b1, 1'b0, 4'h8, 32'h0,          32'h1234};
    vecs[7]  = '{1'b0, 1'b1, 4'h8, 32'h5,          32'h0};
    vecs[8]  = '{1'b1, 1'b0, 4'hB, 32'h0,          32'h1234};
    vecs[9]  = '{1'b1, 1'b1, 4'hC, 32'hFFFF_FFFE,  32'h0};
    vecs[10] = '{1'b1, 1'b0, 4'hC, 32'h0,          32'h0};
    vecs[11] = '{1'b1, 1'b1, 4'hC, 32'h1,          32'h0};
    vecs[12] = '{1'b1, 1'b0, 4'hC, 32'h0,          32'h1};
    vecs[13] = '{1'b1, 1'b1, 4'h8, 32'h3,          32'h0};
    vecs[14] = '{1'b1, 1'b0, 4'h8, 32'h0,          32'h3};
    vecs[15] = '{1'b1, 1'b0, 4'h4, 32'h0,          32'h4};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_irq", 32'(irq), 32'd1);

    for (int i = 0; i < 16; i++) begin
      access(vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].d, r);
      if (!vecs[i].w) check($sformatf("vec%0d", i), r, vecs[i].exp);
    end

    // Single frame, BAUDDIV=3
    sb.push_back('{8'hA5, 4});
    access(1'b1, 1'b1, 4'h0, 32'hA5, r);
    check("push_irq_low", 32'(irq), 32'd0);
    check("push_tx_idle", 32'(tx), 32'd1);
    access(1'b1, 1'b0, 4'h4, 32'h0, r);
    check("status_count1", r, 32'h10);
    check("start_latency", 32'(tx), 32'd0);
    t0 = cyc;
    wait_irq("single_irq", 100);
    check("single_frame_len", cyc - t0, 32'd40);
    repeat (2) @(posedge clk);
    check("single_sb_empty", 32'(sb.size()), 32'd0);

    // Back-to-back frames
    start_q.delete();
    for (int i = 1; i <= 3; i++) sb.push_back('{8'(i), 4});
    for (int i = 1; i <= 3; i++) access(1'b1, 1'b1, 4'h0, 32'(i), r);
    wait_irq("b2b_irq", 500);
    repeat (2) @(posedge clk);
    check("b2b_frames", 32'(start_q.size()), 32'd3);
    if (start_q.size() >= 3) begin
      check("b2b_gap1", start_q[1] - start_q[0], 32'd41);
      check("b2b_gap2", start_q[2] - start_q[1], 32'd41);
    end
    check("b2b_sb_empty", 32'(sb.size()), 32'd0);

    // Overflow with transmitter disabled
    access(1'b1, 1'b1, 4'hC, 32'h0, r);
    for (int i = 0; i < 9; i++) begin
      b = 8'h11 + 8'(i);
      if (i < 8) sb.push_back('{b, 4});
      access(1'b1, 1'b1, 4'h0, 32'(b), r);
    end
    access(1'b1, 1'b0, 4'h4, 32'h0, r);
    check("ovf_status", r, 32'h8A);
    access(1'b1, 1'b1, 4'h4, 32'h8, r);
    access(1'b1, 1'b0, 4'h4, 32'h0, r);
    check("ovf_cleared", r, 32'h82);
    start_q.delete();
    access(1'b1, 1'b1, 4'hC, 32'h1, r);
    wait_irq("ovf_irq", 8 * 41 + 50);
    repeat (2) @(posedge clk);
    check("ovf_frames", 32'(start_q.size()), 32'd8);
    check("ovf_sb_empty", 32'(sb.size()), 32'd0);

    // BAUDDIV change mid-frame affects only the next frame
    start_q.delete();
    sb.push_back('{8'h3C, 4});
    sb.push_back('{8'hC3, 8});
    access(1'b1, 1'b1, 4'h0, 32'h3C, r);
    access(1'b1, 1'b1, 4'h0, 32'hC3, r);
    repeat (10) @(posedge clk);
    access(1'b1, 1'b1, 4'h8, 32'h7, r);
    wait_irq("baud_irq", 300);
    if (start_q.size() >= 2) begin
      check("baud_gap", start_q[1] - start_q[0], 32'd41);
      check("baud_frame2_len", cyc - start_q[1], 32'd80);
    end
    repeat (2) @(posedge clk);
    check("baud_sb_empty", 32'(sb.size()), 32'd0);
    access(1'b1, 1'b1, 4'h8, 32'h3, r);

    // Enable cleared mid-frame: frame completes, no further pop
    start_q.delete();
    sb.push_back('{8'h5A, 4});
    access(1'b1, 1'b1, 4'h0, 32'h5A, r);
    access(1'b1, 1'b1, 4'h0, 32'h77, r);
    repeat (10) @(posedge clk);
    access(1'b1, 1'b1, 4'hC, 32'h0, r);
    repeat (60) @(posedge clk);
    access(1'b1, 1'b0, 4'h4, 32'h0, r);
    check("disable_status", r, 32'h10);
    check("disable_frames", 32'(start_q.size()), 32'd1);
    check("disable_irq", 32'(irq), 32'd0);
    check("disable_sb_empty", 32'(sb.size()), 32'd0);
    do_reset();

    // Reset during DATA bit 4
    access(1'b1, 1'b1, 4'h8, 32'h3, r);
    start_q.delete();
    sb.push_back('{8'h0F, 4});
    access(1'b1, 1'b1, 4'h0, 32'h0F, r);
    repeat (21) @(posedge clk);
    #1;
    check("mid_bit4_low", 32'(tx), 32'd0);
    abort_req = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_reset_tx", 32'(tx), 32'd1);
    check("mid_reset_irq", 32'(irq), 32'd1);
    reset = 1'b0;
    sb.delete();
    start_q.delete();
    access(1'b1, 1'b0, 4'h4, 32'h0, r);
    check("mid_reset_status", r, 32'h4);
    access(1'b1, 1'b0, 4'h8, 32'h0, r);
    check("mid_reset_baud", r, 32'h364);
    repeat (60) @(posedge clk);
    #1;
    check("mid_no_residual", 32'(start_q.size()), 32'd0);
    check("mid_tx_idle", 32'(tx), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
